ape_obi_resp: RTL and testbench

Memory-side responder for the APE core request/response bus (req/add/gnt, r_valid/r_rdata/r_opc). It sits between the core's fetch/load initiator and a variable-latency word-addressed SRAM backend. It grants requests subject to an outstanding limit and range-checks each address. Responses return strictly in request order, with locally generated error responses for out-of-range or misaligned addresses.

---
 rtl/ape_obi_resp.sv | 109 ++++++++++
 tb/tb_ape_obi_resp.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ape_obi_resp.sv
// APE OBI memory-side responder: grants core requests against an outstanding
// limit, range-checks addresses and returns responses strictly in request order.
module ape_obi_resp #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned MAX_OUT   = 2,
  localparam int unsigned AW = $clog2(MEM_WORDS)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_i,
  input  logic [31:0]   add_i,
  output logic          gnt_o,
  output logic          r_valid_o,
  output logic [31:0]   r_rdata_o,
  output logic          r_opc_o,
  output logic          mem_req_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [31:0]   mem_rdata_i
);

  localparam int unsigned   CW       = $clog2(MAX_OUT + 1);
  localparam int unsigned   PW       = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUT);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUT - 1);
  localparam logic [32:0]   ADDR_LO  = {1'b0, BASE_ADDR};
  localparam logic [32:0]   ADDR_HI  = ADDR_LO + (33'(MEM_WORDS) << 2);

  logic [CW-1:0]      cnt, mem_cnt, dcnt;
  logic [PW-1:0]      ord_wr, ord_rd, dat_wr, dat_rd;
  logic [MAX_OUT-1:0] ord_q;
  logic [31:0]        dat_q [MAX_OUT];

  logic ok, space, ord_empty, dat_empty, err_now;
  logic head_err, head_mem;
  logic emit_err, emit_fifo, emit_byp, emit;
  logic ord_push, ord_pop, dat_push, mem_push, mem_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign ok = (add_i[1:0] == 2'b00) && ({1'b0, add_i} >= ADDR_LO) && ({1'b0, add_i} < ADDR_HI);
  assign space = (cnt != CNT_MAX);

  assign gnt_o      = rst_ni & req_i & space & (ok ? mem_gnt_i : 1'b1);
  assign mem_req_o  = rst_ni & req_i & ok & space;
  assign mem_addr_o = AW'((add_i - BASE_ADDR) >> 2);

  // An error granted into an empty order queue is answered the same cycle,
  // so it never occupies a queue slot.
  assign ord_empty = (cnt == '0);
  assign dat_empty = (dcnt == '0);
  assign err_now   = ord_empty & gnt_o & ~ok;
  assign head_err  = ord_empty ? err_now : ord_q[ord_rd];
  assign head_mem  = ~ord_empty & ~ord_q[ord_rd];

  assign emit_err  = head_err;
  assign emit_fifo = head_mem & ~dat_empty;
  assign emit_byp  = head_mem & dat_empty & mem_rvalid_i;
  assign emit      = emit_err | emit_fifo | emit_byp;

  assign ord_push = gnt_o & ~err_now;
  assign ord_pop  = emit & ~err_now;
  assign mem_push = gnt_o & ok;
  assign mem_pop  = emit_fifo | emit_byp;
  // Data for a mem entry that is not yet the head waits here; orphan beats are dropped.
  assign dat_push = mem_rvalid_i & ~emit_byp & (mem_cnt > dcnt);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt       <= '0;
      mem_cnt   <= '0;
      dcnt      <= '0;
      ord_wr    <= '0;
      ord_rd    <= '0;
      dat_wr    <= '0;
      dat_rd    <= '0;
      ord_q     <= '0;
      r_valid_o <= 1'b0;
      r_opc_o   <= 1'b0;
      r_rdata_o <= '0;
    end else begin
      cnt     <= cnt + CW'(gnt_o) - CW'(emit);
      mem_cnt <= mem_cnt + CW'(mem_push) - CW'(mem_pop);
      dcnt    <= dcnt + CW'(dat_push) - CW'(emit_fifo);
      if (ord_push) begin
        ord_q[ord_wr] <= ~ok;
        ord_wr        <= ptr_next(ord_wr);
      end
      if (ord_pop)   ord_rd <= ptr_next(ord_rd);
      if (dat_push)  dat_wr <= ptr_next(dat_wr);
      if (emit_fifo) dat_rd <= ptr_next(dat_rd);
      r_valid_o <= emit;
      r_opc_o   <= emit_err;
      r_rdata_o <= emit_fifo ? dat_q[dat_rd] : (emit_byp ? mem_rdata_i : '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (dat_push) dat_q[dat_wr] <= mem_rdata_i;
  end

  a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_rvalid_i |-> (mem_cnt > dcnt));

endmodule

// File: tb/tb_ape_obi_resp.sv
// Bench for ape_obi_resp: directed scenarios plus random traffic, checked every
// cycle against an in-order response model with a bench-side backend.
module tb_ape_obi_resp;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          WORDS = 1024;
  localparam int          MAXO  = 2;
  localparam int          AW    = 10;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          req_i = 1'b0;
  logic [31:0]   add_i = '0;
  logic          gnt_o, r_valid_o, r_opc_o, mem_req_o;
  logic [31:0]   r_rdata_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_gnt_i = 1'b0;
  logic          mem_rvalid_i = 1'b0;
  logic [31:0]   mem_rdata_i = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { logic err; logic [31:0] data; int e; } resp_t;
  typedef struct { int ret; logic [31:0] data; } ret_t;
  resp_t exq[$];
  ret_t  sched[$];
  int    last_e = -1000;
  int    last_ret = -1000;
  logic [31:0] mem_m [WORDS];

  always #5 clk_i = ~clk_i;

  ape_obi_resp #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS), .MAX_OUT(MAXO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .add_i(add_i), .gnt_o(gnt_o),
    .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o), .r_opc_o(r_opc_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic addr_ok(input logic [31:0] a);
    longint x;
    x = {32'b0, a};
    return (a[1:0] == 2'b00) && (x >= {32'b0, BASE}) && (x < {32'b0, BASE} + longint'(4 * WORDS));
  endfunction

  // One clock cycle: drive inputs, play back backend data, check all outputs.
  task automatic step(input logic rq, input logic [31:0] ad, input logic mg, input int lat,
                      output logic g);
    logic ok_m, mreq_m;
    int e;
    resp_t r;
    ret_t b;
    logic [AW-1:0] widx;
    @(posedge clk_i);
    cyc++;
    #1;
    req_i = rq;
    add_i = ad;
    mem_gnt_i = mg;
    if (sched.size() > 0 && sched[0].ret == cyc) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i = sched[0].data;
      void'(sched.pop_front());
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i = $urandom;
    end
    #2;
    if (exq.size() > 0 && exq[0].e == cyc - 1) begin
      chk("r_valid", 32'(r_valid_o), 32'd1);
      chk("r_opc", 32'(r_opc_o), 32'(exq[0].err));
      chk("r_rdata", r_rdata_o, exq[0].data);
      void'(exq.pop_front());
    end else begin
      chk("r_valid_idle", 32'(r_valid_o), 32'd0);
      chk("r_rdata_idle", r_rdata_o, 32'd0);
    end
    ok_m   = addr_ok(ad);
    mreq_m = rq && ok_m && (exq.size() < MAXO);
    g      = rq && (exq.size() < MAXO) && (ok_m ? mg : 1'b1);
    chk("gnt", 32'(gnt_o), 32'(g));
    chk("mem_req", 32'(mem_req_o), 32'(mreq_m));
    if (mreq_m) chk("mem_addr", 32'(mem_addr_o), (ad - BASE) >> 2);
    if (g) begin
      if (ok_m) begin
        widx = AW'((ad - BASE) >> 2);
        last_ret = imax(cyc + lat, last_ret + 1);
        b.ret = last_ret;
        b.data = mem_m[widx];
        sched.push_back(b);
        e = imax(last_ret, last_e + 1);
        r.data = mem_m[widx];
      end else begin
        e = imax(cyc, last_e + 1);
        r.data = '0;
      end
      last_e = e;
      r.err = ~ok_m;
      r.e = e;
      exq.push_back(r);
    end
  endtask

  task automatic drain();
    logic g;
    for (int i = 0; i < 60 && exq.size() > 0; i++) step(1'b0, 32'd0, 1'b1, 1, g);
    chk("drain_bound", 32'(exq.size()), 32'd0);
    sched.delete();
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    cyc++;
    #1;
    chk("rv_before_reset", 32'(r_valid_o), 32'((exq.size() > 0) && (exq[0].e == cyc - 1)));
    rst_ni = 1'b0;
    req_i = 1'b1;
    add_i = BASE + 32'd8;
    mem_gnt_i = 1'b1;
    #1;
    chk("rst_r_valid", 32'(r_valid_o), 32'd0);
    chk("rst_r_rdata", r_rdata_o, 32'd0);
    chk("rst_r_opc", 32'(r_opc_o), 32'd0);
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    repeat (2) begin
      @(posedge clk_i);
      cyc++;
    end
    #1;
    rst_ni = 1'b1;
    req_i = 1'b0;
    mem_rvalid_i = 1'b0;
    exq.delete();
    sched.delete();
    last_e = -1000;
    last_ret = -1000;
  endtask

  logic g;
  int ngr;
  logic seen;
  logic hold;
  logic rrq;
  logic [31:0] ra;

  initial begin
    for (int i = 0; i < WORDS; i++) mem_m[i] = $urandom;
    mem_m[2] = 32'hDEAD_BEEF;
    mem_m[5] = 32'h1111_1111;
    mem_m[7] = 32'hCAFE_0007;

    #2 rst_ni = 1'b0;
    req_i = 1'b1;
    add_i = BASE + 32'd8;
    mem_gnt_i = 1'b1;
    #1;
    chk("init_r_valid", 32'(r_valid_o), 32'd0);
    chk("init_r_rdata", r_rdata_o, 32'd0);
    chk("init_r_opc", 32'(r_opc_o), 32'd0);
    chk("init_gnt", 32'(gnt_o), 32'd0);
    chk("init_mem_req", 32'(mem_req_o), 32'd0);
    req_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // single in-range read, 1-cycle backend
    step(1'b1, BASE + 32'd8, 1'b1, 1, g);
    chk("read_gnt", 32'(gnt_o), 32'd1);
    chk("read_addr", 32'(mem_addr_o), 32'd2);
    step(1'b0, 32'd0, 1'b1, 1, g);
    step(1'b0, 32'd0, 1'b1, 1, g);
    chk("read_valid", 32'(r_valid_o), 32'd1);
    chk("read_data", r_rdata_o, 32'hDEAD_BEEF);
    chk("read_opc", 32'(r_opc_o), 32'd0);
    drain();

    // out-of-range and misaligned faults
    step(1'b1, BASE + 32'(4 * WORDS), 1'b1, 1, g);
    chk("oor_mem_req", 32'(mem_req_o), 32'd0);
    chk("oor_gnt", 32'(gnt_o), 32'd1);
    step(1'b0, 32'd0, 1'b1, 1, g);
    chk("oor_valid", 32'(r_valid_o), 32'd1);
    chk("oor_opc", 32'(r_opc_o), 32'd1);
    chk("oor_data", r_rdata_o, 32'd0);
    step(1'b1, BASE + 32'd2, 1'b1, 1, g);
    chk("mis_mem_req", 32'(mem_req_o), 32'd0);
    chk("mis_gnt", 32'(gnt_o), 32'd1);
    step(1'b0, 32'd0, 1'b1, 1, g);
    chk("mis_valid", 32'(r_valid_o), 32'd1);
    chk("mis_opc", 32'(r_opc_o), 32'd1);
    drain();

    // error behind a slow mem read must not overtake it
    step(1'b1, BASE + 32'd20, 1'b1, 3, g);
    step(1'b1, BASE - 32'd4, 1'b1, 1, g);
    chk("ord_err_gnt", 32'(gnt_o), 32'd1);
    step(1'b0, 32'd0, 1'b1, 1, g);
    chk("ord_wait1", 32'(r_valid_o), 32'd0);
    step(1'b0, 32'd0, 1'b1, 1, g);
    chk("ord_wait2", 32'(r_valid_o), 32'd0);
    step(1'b0, 32'd0, 1'b1, 1, g);
    chk("ord_first_valid", 32'(r_valid_o), 32'd1);
    chk("ord_first_opc", 32'(r_opc_o), 32'd0);
    chk("ord_first_data", r_rdata_o, 32'h1111_1111);
    step(1'b0, 32'd0, 1'b1, 1, g);
    chk("ord_second_valid", 32'(r_valid_o), 32'd1);
    chk("ord_second_opc", 32'(r_opc_o), 32'd1);
    drain();

    // outstanding limit with a 5-cycle backend and req held high
    ngr = 0;
    seen = 1'b0;
    ra = BASE + 32'h100;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b1, ra, 1'b1, 5, g);
      if (r_valid_o) seen = 1'b1;
      else if (gnt_o) begin
        ngr++;
        ra = ra + 32'd4;
      end
    end
    chk("limit_seen_resp", 32'(seen), 32'd1);
    chk("limit_grants", 32'(ngr), 32'd2);
    drain();

    // backend stall
    for (int i = 0; i < 4; i++) begin
      step(1'b1, BASE + 32'h40, 1'b0, 1, g);
      chk("stall_mem_req", 32'(mem_req_o), 32'd1);
      chk("stall_gnt", 32'(gnt_o), 32'd0);
    end
    step(1'b1, BASE + 32'h40, 1'b1, 1, g);
    chk("stall_release_gnt", 32'(gnt_o), 32'd1);
    drain();

    // reset while a response is on the bus
    step(1'b1, BASE + 32'd2, 1'b1, 1, g);
    do_reset();

    // reset with two mem reads outstanding, then a fresh read
    step(1'b1, BASE + 32'h80, 1'b1, 10, g);
    step(1'b1, BASE + 32'h84, 1'b1, 10, g);
    do_reset();
    step(1'b1, BASE + 32'd28, 1'b1, 2, g);
    chk("post_rst_gnt", 32'(gnt_o), 32'd1);
    step(1'b0, 32'd0, 1'b1, 1, g);
    step(1'b0, 32'd0, 1'b1, 1, g);
    step(1'b0, 32'd0, 1'b1, 1, g);
    chk("post_rst_valid", 32'(r_valid_o), 32'd1);
    chk("post_rst_data", r_rdata_o, 32'hCAFE_0007);
    drain();

    // random traffic
    hold = 1'b0;
    rrq = 1'b0;
    ra = BASE;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        rrq = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 9))
          0: ra = BASE + 32'(4 * WORDS);
          1: ra = BASE - 32'd4;
          2: ra = BASE + ($urandom_range(0, WORDS - 1) << 2) + $urandom_range(1, 3);
          3: ra = 32'hFFFF_FFFC;
          4: ra = BASE + 32'(4 * WORDS - 4);
          default: ra = BASE + ($urandom_range(0, WORDS - 1) << 2);
        endcase
      end
      step(rrq, ra, ($urandom_range(0, 3) != 0), int'($urandom_range(1, 4)), g);
      hold = rrq && !g;
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
